// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default constants for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // A lone requester always wins; on a tie the one not granted last time wins.
  function automatic owner_t pick_owner(input logic if_req, input logic d_req,
                                        input owner_t last_grant);
    if (if_req && d_req)
      return (last_grant == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    else if (d_req)
      return OWN_DATA;
    else
      return OWN_FETCH;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, with a BUSY
// timeout that aborts a stalled access and flags err alongside the ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  owner_t           last_grant;
  owner_t           grant_owner;
  logic [CNT_W-1:0] cnt;

  logic grant_valid, busy, finish, expired;
  logic capture_if, capture_d;
  logic [DATA_W-1:0] capture_val;
  logic nxt_mem_en, nxt_if_ack, nxt_d_ack, nxt_err;

  assign busy        = (state == ST_BUSY_I) || (state == ST_BUSY_D);
  assign grant_valid = (state == ST_IDLE) && (if_req || d_req);
  assign grant_owner = pick_owner(if_req, d_req, last_grant);
  assign finish      = busy && (mem_ready || (cnt == CNT_LAST));
  assign expired     = busy && !mem_ready && (cnt == CNT_LAST);
  assign capture_val = mem_ready ? mem_rdata : '0;
  // A store never writes back into d_rdata, even when it is aborted.
  assign capture_if  = (state == ST_BUSY_I) && finish;
  assign capture_d   = (state == ST_BUSY_D) && finish && !mem_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_valid)
          state_nxt = (grant_owner == OWN_FETCH) ? ST_BUSY_I : ST_BUSY_D;
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (finish) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered strobes, derived from the transition taken.
  always_comb begin
    nxt_mem_en = (state_nxt == ST_BUSY_I) || (state_nxt == ST_BUSY_D);
    nxt_if_ack = (state == ST_BUSY_I) && finish;
    nxt_d_ack  = (state == ST_BUSY_D) && finish;
    nxt_err    = expired;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;
    end else begin
      mem_en <= nxt_mem_en;
      if_ack <= nxt_if_ack;
      d_ack  <= nxt_d_ack;
      err    <= nxt_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (grant_valid) begin
      cnt <= '0;
    end else if (busy && (cnt != CNT_LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= OWN_DATA;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else if (grant_valid) begin
      last_grant <= grant_owner;
      if (grant_owner == OWN_FETCH) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end else begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if (capture_if) if_rdata <= capture_val;
      if (capture_d)  d_rdata  <= capture_val;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized transfers against a transaction-level model of the
// arbiter: tie rotation, memory contents, held rdata and timeout behaviour.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [256];
  logic          model_last_data;
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_d_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_ack"}, if_ack, 0);
    check({tag, "_d_ack"}, d_ack, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a later idle negedge.
  task automatic txn(input logic ir, input logic dr, input logic we,
                     input logic [AW-1:0] ia, input logic [AW-1:0] da,
                     input logic [DW-1:0] wd, input int lat);
    logic          win_d;
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic [DW-1:0] erd;
    bit            tout;
    int            waits;
    if_req = ir; if_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    mem_ready = 1'b0;
    win_d = (ir && dr) ? !model_last_data : dr;
    model_last_data = win_d;
    ea   = win_d ? da : ia;
    ewe  = win_d && we;
    ewd  = win_d ? wd : '0;
    tout = (lat >= TO);
    waits = tout ? TO : lat;
    @(posedge clk); #1;
    check("grant_en", mem_en, 1);
    check("grant_addr", mem_addr, ea);
    check("grant_we", mem_we, ewe);
    check("grant_wdata", mem_wdata, ewd);
    for (int k = 0; k < waits; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      check("busy_en", mem_en, 1);
      check("busy_addr", mem_addr, ea);
      check("busy_we", mem_we, ewe);
      check("busy_ack", {if_ack, d_ack}, 0);
      @(posedge clk);
    end
    if (!tout) begin
      @(negedge clk);
      check("ready_en", mem_en, 1);
      mem_ready = 1'b1;
      if (ewe) begin
        mem_rdata = $urandom;
        model_mem[ea] = wd;
        erd = '0;
      end else begin
        mem_rdata = model_mem[mem_addr];
        erd = model_mem[ea];
      end
      @(posedge clk);
    end else begin
      erd = '0;
    end
    #1;
    mem_ready = 1'b0;
    if (!win_d) exp_if_rdata = erd;
    else if (!ewe) exp_d_rdata = erd;
    check("done_if_ack", if_ack, !win_d);
    check("done_d_ack", d_ack, win_d);
    check("done_err", err, tout);
    check("done_en", mem_en, 0);
    check("done_if_rdata", if_rdata, exp_if_rdata);
    check("done_d_rdata", d_rdata, exp_d_rdata);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("idle_ack", {if_ack, d_ack, err}, 0);
    check("idle_en", mem_en, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_last_data = 1'b1;
    exp_if_rdata = '0;
    exp_d_rdata = '0;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = $urandom;
    model_mem[8'h10] = 32'hDEADBEEF;
    @(negedge clk);
    do_reset();

    // fetch with immediate ready, then a slow store
    txn(1, 0, 0, 8'h10, 8'h00, 32'h0, 0);
    check("fetch_rdata", if_rdata, 32'hDEADBEEF);
    txn(0, 1, 1, 8'h00, 8'h20, 32'h12345678, 2);
    check("store_mem", model_mem[8'h20], 32'h12345678);

    // tie rotation from reset
    do_reset();
    txn(1, 1, 0, 8'h30, 8'h31, 32'h0, 0);
    txn(0, 1, 0, 8'h30, 8'h31, 32'h0, 1);
    txn(1, 1, 0, 8'h32, 8'h33, 32'h0, 0);
    txn(1, 1, 0, 8'h34, 8'h35, 32'h0, 0);

    // load timeout
    txn(0, 1, 0, 8'h00, 8'h40, 32'h0, TO);
    check("timeout_rdata", d_rdata, 0);

    // stray ready while idle
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    repeat (3) begin
      @(negedge clk);
      check("stray_ack", {if_ack, d_ack, err}, 0);
      check("stray_en", mem_en, 0);
      check("stray_if_rdata", if_rdata, exp_if_rdata);
      check("stray_d_rdata", d_rdata, exp_d_rdata);
    end
    mem_ready = 1'b0;

    // reset during the second BUSY cycle, fetch pending across release
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h50;
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_en", mem_en, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    d_req = 1'b0;
    if_req = 1'b1; if_addr = 8'h44;
    #1;
    model_last_data = 1'b1;
    exp_if_rdata = '0;
    exp_d_rdata = '0;
    check_all_zero("midbusy");
    @(negedge clk);
    check("midbusy_noack", {if_ack, d_ack}, 0);
    reset = 1'b0;
    txn(1, 0, 0, 8'h44, 8'h00, 32'h0, 1);

    for (int n = 0; n < 40; n++) begin
      logic ir, dr, we;
      int   lat;
      ir  = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      lat = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 4);
      if (lat >= TO) we = 1'b0;
      txn(ir, dr, we, 8'($urandom), 8'($urandom), $urandom, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
